// File: rtl/video_pkg.sv
// Shared TMDS helpers: control symbols, colour-depth expansion and ones counting.
package video_pkg;

  localparam logic [9:0] CTL00 = 10'b1101010100;
  localparam logic [9:0] CTL01 = 10'b0010101011;
  localparam logic [9:0] CTL10 = 10'b0101010100;
  localparam logic [9:0] CTL11 = 10'b1010101011;

  // MSB replication: the depth-bit pattern repeats from bit 7 downwards.
  function automatic logic [7:0] expand_depth(input logic [7:0] din, input int depth);
    logic [7:0] d8;
    d8 = '0;
    for (int i = 0; i < 8; i++) begin
      d8[7-i] = din[depth - 1 - (i % depth)];
    end
    return d8;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctl_symbol(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = CTL00;
      2'b01:   s = CTL01;
      2'b10:   s = CTL10;
      default: s = CTL11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS data channel: stage 1 transition-minimises, stage 2 DC-balances
// against this channel's own running disparity.
module tmds_channel_enc
  import video_pkg::*;
#(
  parameter int C_depth = 3
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic [C_depth-1:0] din,
  input  logic               blank,
  input  logic [1:0]         ctl,
  output logic [9:0]         tmds,
  output logic [4:0]         disp
);

  logic [7:0]        d8;
  logic [3:0]        n1;
  logic              use_xnor;
  logic [8:0]        qm_c;

  logic [8:0]        s1_qm;
  logic              s1_blank;
  logic [1:0]        s1_ctl;

  logic [3:0]        n1q;
  logic              q8;
  logic signed [5:0] bal;
  logic signed [5:0] cnt_w;
  logic signed [5:0] cnt_c;
  logic [9:0]        sym_c;
  logic signed [4:0] cnt;

  always_comb begin
    logic [8:0] q;
    d8       = expand_depth(8'(din), C_depth);
    n1       = popcount8(d8);
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d8[0]);
    q        = '0;
    q[0]     = d8[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d8[i]) : (q[i-1] ^ d8[i]);
    end
    q[8]     = ~use_xnor;
    qm_c     = q;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      s1_qm    <= '0;
      s1_blank <= 1'b1;
      s1_ctl   <= 2'b00;
    end else begin
      s1_qm    <= qm_c;
      s1_blank <= blank;
      s1_ctl   <= ctl;
    end
  end

  // bal is N1-N0 of q_m[7:0]; 6-bit math keeps intermediate sums clear of wrap.
  always_comb begin
    n1q   = popcount8(s1_qm[7:0]);
    q8    = s1_qm[8];
    bal   = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    cnt_w = {cnt[4], cnt};
    sym_c = CTL00;
    cnt_c = cnt_w;
    if (s1_blank) begin
      sym_c = ctl_symbol(s1_ctl);
      cnt_c = '0;
    end else if (cnt == 5'sd0 || bal == 6'sd0) begin
      sym_c = {~q8, q8, q8 ? s1_qm[7:0] : ~s1_qm[7:0]};
      cnt_c = q8 ? (cnt_w + bal) : (cnt_w - bal);
    end else if ((cnt > 5'sd0 && bal > 6'sd0) || (cnt < 5'sd0 && bal < 6'sd0)) begin
      sym_c = {1'b1, q8, ~s1_qm[7:0]};
      cnt_c = cnt_w - bal + (q8 ? 6'sd2 : 6'sd0);
    end else begin
      sym_c = {1'b0, q8, s1_qm[7:0]};
      cnt_c = cnt_w + bal - (q8 ? 6'sd0 : 6'sd2);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      tmds <= CTL00;
      cnt  <= '0;
    end else begin
      tmds <= sym_c;
      cnt  <= cnt_c[4:0];
    end
  end

  assign disp = cnt;

endmodule

// File: rtl/tmds_encoder_multi.sv
// Multi-channel DVI encoder: one tmds_channel_enc per colour channel, with
// hsync/vsync steered onto channel 0's control pair.
module tmds_encoder_multi #(
  parameter int C_depth    = 3,
  parameter int C_channels = 3
) (
  input  logic                                              clk_pixel,
  input  logic                                              reset,
  input  logic [C_channels*C_depth-1:0]                     in_data,
  input  logic                                              in_blank,
  input  logic                                              in_hsync,
  input  logic                                              in_vsync,
  input  logic [(C_channels > 1 ? 2*(C_channels-1) : 1)-1:0] in_ctl,
  output logic [C_channels*10-1:0]                          out_tmds,
  output logic [C_channels*5-1:0]                           out_disp
);

  for (genvar k = 0; k < C_channels; k++) begin : g_ch
    logic [1:0] ctl_k;

    if (k == 0) begin : g_sync
      assign ctl_k = {in_vsync, in_hsync};
    end else begin : g_ctl
      assign ctl_k = in_ctl[2*k-1 -: 2];
    end

    tmds_channel_enc #(
      .C_depth(C_depth)
    ) u_enc (
      .clk_pixel(clk_pixel),
      .reset    (reset),
      .din      (in_data[k*C_depth +: C_depth]),
      .blank    (in_blank),
      .ctl      (ctl_k),
      .tmds     (out_tmds[k*10 +: 10]),
      .disp     (out_disp[k*5 +: 5])
    );
  end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Bench for tmds_encoder_multi: cycle-level reference model feeding a scoreboard,
// plus directed checks of hand-derived symbols against recorded output history.
module tb_tmds_encoder_multi;

  localparam int C_DEPTH    = 3;
  localparam int C_CHANNELS = 3;
  localparam int DW = C_CHANNELS * C_DEPTH;
  localparam int CW = 2 * (C_CHANNELS - 1);
  localparam int TW = C_CHANNELS * 10;
  localparam int PW = C_CHANNELS * 5;
  localparam int W  = TW + PW;

  logic          clk_pixel = 1'b0;
  logic          reset     = 1'b1;
  logic [DW-1:0] in_data   = '0;
  logic          in_blank  = 1'b1;
  logic          in_hsync  = 1'b0;
  logic          in_vsync  = 1'b0;
  logic [CW-1:0] in_ctl    = '0;
  logic [TW-1:0] out_tmds;
  logic [PW-1:0] out_disp;

  tmds_encoder_multi #(
    .C_depth   (C_DEPTH),
    .C_channels(C_CHANNELS)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset    (reset),
    .in_data  (in_data),
    .in_blank (in_blank),
    .in_hsync (in_hsync),
    .in_vsync (in_vsync),
    .in_ctl   (in_ctl),
    .out_tmds (out_tmds),
    .out_disp (out_disp)
  );

  // clock / cycle count
  always #5 clk_pixel = ~clk_pixel;
  int cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0]            exp_q[$];
  logic [C_CHANNELS*8:0]   chk_q[$];
  logic [TW-1:0]           hist_t[int];
  logic [PW-1:0]           hist_d[int];

  logic [9:0] ctl_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // reference model
  function automatic logic [7:0] ref_expand(input logic [C_DEPTH-1:0] v);
    logic [63:0] rep;
    rep = '0;
    for (int j = 0; j < 8; j++) rep = (rep << C_DEPTH) | 64'(v);
    return 8'(rep >> (8 * C_DEPTH - 8));
  endfunction

  task automatic ref_encode(input logic [7:0] d, input int cin, output logic [9:0] sym, output int cout);
    int ones, bal, par;
    logic xn, q8;
    logic [7:0] q;
    ones = $countones(d);
    xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    for (int i = 0; i < 8; i++) begin
      par  = $countones(d & 8'((1 << (i + 1)) - 1)) % 2;
      q[i] = 1'(par) ^ (xn ? 1'(i % 2) : 1'b0);
    end
    q8  = ~xn;
    bal = 2 * $countones(q) - 8;
    if (cin == 0 || bal == 0) begin
      sym  = {~q8, q8, q8 ? q : ~q};
      cout = cin + (q8 ? bal : -bal);
    end else if ((cin > 0 && bal > 0) || (cin < 0 && bal < 0)) begin
      sym  = {1'b1, q8, ~q};
      cout = cin + (q8 ? 2 : 0) - bal;
    end else begin
      sym  = {1'b0, q8, q};
      cout = cin - (q8 ? 0 : 2) + bal;
    end
  endtask

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] q, d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ ~s[8];
    return d;
  endfunction

  logic       pend_blank;
  logic [1:0] pend_ctl [C_CHANNELS];
  logic [7:0] pend_d8  [C_CHANNELS];
  int         cnt      [C_CHANNELS];

  // Expected output one edge after these inputs are applied.
  task automatic model_step(input logic rst, input logic blank, input logic hs, input logic vs,
                            input logic [CW-1:0] ctl, input logic [DW-1:0] data);
    logic [W-1:0]          e;
    logic [C_CHANNELS*8:0] inf;
    logic [9:0]            sym;
    int                    co;
    e   = '0;
    inf = '0;
    if (rst) begin
      for (int ch = 0; ch < C_CHANNELS; ch++) begin
        e[ch*10 +: 10] = 10'h354;
        cnt[ch] = 0;
        pend_ctl[ch] = 2'b00;
        pend_d8[ch] = 8'h00;
      end
      pend_blank = 1'b1;
    end else begin
      inf[C_CHANNELS*8] = ~pend_blank;
      for (int ch = 0; ch < C_CHANNELS; ch++) begin
        if (pend_blank) begin
          sym = ctl_tab[pend_ctl[ch]];
          cnt[ch] = 0;
        end else begin
          ref_encode(pend_d8[ch], cnt[ch], sym, co);
          cnt[ch] = co;
        end
        e[ch*10 +: 10]     = sym;
        e[TW + ch*5 +: 5]  = 5'(cnt[ch]);
        inf[ch*8 +: 8]     = pend_d8[ch];
      end
      pend_blank = blank;
      for (int ch = 0; ch < C_CHANNELS; ch++) begin
        if (ch == 0) pend_ctl[ch] = {vs, hs};
        else         pend_ctl[ch] = ctl[2*ch-1 -: 2];
        pend_d8[ch] = ref_expand(data[ch*C_DEPTH +: C_DEPTH]);
      end
    end
    exp_q.push_back(e);
    chk_q.push_back(inf);
  endtask

  // driver
  task automatic drive(input logic rst, input logic blank, input logic hs, input logic vs,
                       input logic [CW-1:0] ctl, input logic [DW-1:0] data, output int t);
    @(negedge clk_pixel);
    reset    = rst;
    in_blank = blank;
    in_hsync = hs;
    in_vsync = vs;
    in_ctl   = ctl;
    in_data  = data;
    t = cyc;
    model_step(rst, blank, hs, vs, ctl, data);
  endtask

  task automatic drive_rand(input logic rst, input logic blank, output int t);
    drive(rst, blank, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          CW'($urandom()), DW'($urandom()), t);
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0]          e;
    logic [C_CHANNELS*8:0] inf;
    logic [C_CHANNELS*8-1:0] dec;
    int v, maxabs;
    forever begin
      @(posedge clk_pixel);
      #1;
      hist_t[cyc] = out_tmds;
      hist_d[cyc] = out_disp;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        inf = chk_q.pop_front();
        check("scoreboard", 64'({out_disp, out_tmds}), 64'(e));
        if (inf[C_CHANNELS*8]) begin
          for (int ch = 0; ch < C_CHANNELS; ch++) dec[ch*8 +: 8] = tmds_decode(out_tmds[ch*10 +: 10]);
          check("decode", 64'(dec), 64'(inf[C_CHANNELS*8-1:0]));
        end
        maxabs = 0;
        for (int ch = 0; ch < C_CHANNELS; ch++) begin
          v = int'($signed(out_disp[ch*5 +: 5]));
          if (v < 0) v = -v;
          if (v > maxabs) maxabs = v;
        end
        n_cmp++;
        if (maxabs > 8) begin
          n_err++;
          $display("FAIL disp_bound: got |disp| %0d want <= 8", maxabs);
        end
      end
    end
  end

  task automatic check_out(input string name, input int t, input logic [TW-1:0] et, input logic [PW-1:0] ed);
    check(name, 64'({hist_d[t], hist_t[t]}), 64'({ed, et}));
  endtask

  localparam logic [TW-1:0] RST_T = {C_CHANNELS{10'h354}};

  int t_rst [3];
  int t_rel, t_k0, t_k1, t_w, t_mr, t_mr_rel, t_tmp;
  int t_ctl [4];
  logic [TW-1:0] v_ctl;

  initial begin
    for (int i = 0; i < 3; i++) drive_rand(1'b1, 1'($urandom_range(0, 1)), t_rst[i]);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, t_rel);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, t_tmp);

    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1'(k), 1'(k >> 1), '0, DW'($urandom()), t_ctl[k]);

    // black then white straight out of blanking
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, t_k0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, {DW{1'b1}}, t_k1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, t_tmp);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, {DW{1'b1}}, t_w);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, {C_CHANNELS{3'b101}}, t_tmp);

    for (int i = 0; i < 10000; i++) drive_rand(1'b0, 1'((i % 64) < 8), t_tmp);

    for (int i = 0; i < 5; i++) drive_rand(1'b0, 1'b0, t_tmp);
    drive_rand(1'b1, 1'b0, t_mr);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, t_mr_rel);
    for (int i = 0; i < 4; i++) drive_rand(1'b0, 1'b0, t_tmp);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, t_tmp);

    repeat (3) @(posedge clk_pixel);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    for (int i = 0; i < 3; i++) check_out("reset_hold", t_rst[i] + 1, RST_T, '0);
    check_out("release_cycle1", t_rel + 1, RST_T, '0);
    check_out("release_cycle2", t_rel + 2, RST_T, '0);
    for (int k = 0; k < 4; k++) begin
      v_ctl = RST_T;
      v_ctl[9:0] = ctl_tab[k];
      check_out("ctl_symbol", t_ctl[k] + 2, v_ctl, '0);
    end
    // 0x00 from cnt 0: XOR path, 0x100, disp -8. 0xFF next: not inverted
    // since cnt<0 and N1>N0, giving 0x0FF and -8 - 2 + 8 = -2.
    check_out("black_first", t_k0 + 2, {C_CHANNELS{10'h100}}, {C_CHANNELS{5'h18}});
    check_out("white_after_black", t_k1 + 2, {C_CHANNELS{10'h0FF}}, {C_CHANNELS{5'h1E}});
    check_out("ones_first", t_w + 2, {C_CHANNELS{10'h200}}, {C_CHANNELS{5'h18}});
    check_out("midline_reset", t_mr + 1, RST_T, '0);
    check_out("post_reset_gap", t_mr_rel + 1, RST_T, '0);
    check_out("post_reset_pixel", t_mr_rel + 2, {C_CHANNELS{10'h100}}, {C_CHANNELS{5'h18}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
